// File: rtl/input_debounce.sv
// Input conditioning for board switches and buttons.
// Every raw bit passes through a 2-flop synchroniser and a per-bit debounce
// counter. Debounced levels and single-cycle edge pulses are all registered.
module input_debounce #(
  parameter int SW_W            = 8,
  parameter int BTN_W           = 5,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] btn,
  output logic [SW_W-1:0]  sw_db,
  output logic [BTN_W-1:0] btn_db,
  output logic [BTN_W-1:0] btn_rise,
  output logic [BTN_W-1:0] btn_fall,
  output logic             sw_chg
);

  // Switches occupy the low bits of the combined vector, buttons the high bits.
  localparam int TW = SW_W + BTN_W;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [TW-1:0]    raw;
  logic [TW-1:0]    s1_q;
  logic [TW-1:0]    s2_q;
  logic [TW-1:0]    db_q;
  logic [TW-1:0]    db_d;
  logic [TW-1:0]    upd;
  logic [CW-1:0]    cnt_q [TW];
  logic [CW-1:0]    cnt_d [TW];
  logic [BTN_W-1:0] rise_q;
  logic [BTN_W-1:0] fall_q;
  logic             chg_q;

  assign raw = {btn, sw};

  // Two-flop synchroniser; only s2 is consumed by the debounce logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Per-bit debounce next state: count consecutive mismatches, accept the
  // new level on the N-th one; any agreement clears the count.
  always_comb begin
    for (int i = 0; i < TW; i++) begin
      upd[i]   = 1'b0;
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          upd[i]  = 1'b1;
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce state registers: counters and accepted levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q <= '0;
      for (int i = 0; i < TW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < TW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Edge pulses registered alongside the level update so they coincide with
  // the cycle in which the new debounced value first appears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      rise_q <= upd[TW-1:SW_W] & s2_q[TW-1:SW_W];
      fall_q <= upd[TW-1:SW_W] & ~s2_q[TW-1:SW_W];
      chg_q  <= |upd[SW_W-1:0];
    end
  end

  assign sw_db    = db_q[SW_W-1:0];
  assign btn_db   = db_q[TW-1:SW_W];
  assign btn_rise = rise_q;
  assign btn_fall = fall_q;
  assign sw_chg   = chg_q;

endmodule
